// File: rtl/vga_capture.sv
// VGA receive side: synchronizes RGB/sync pins, recovers line/frame timing, locks after two
// consistent frames and emits an (x, y, colour) pixel-write stream for the active window.
module vga_capture #(
   parameter int HRES      = 800,
   parameter int VRES      = 600,
   parameter int H_START   = 216,
   parameter int V_START   = 27,
   parameter int HPOL      = 1,
   parameter int VPOL      = 1,
   parameter int MIN_LINE  = 64,
   parameter int MIN_FRAME = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        red,
   input  logic        green,
   input  logic        blue,
   input  logic        hsync,
   input  logic        vsync,
   output logic        pix_valid,
   output logic [10:0] pix_x,
   output logic [10:0] pix_y,
   output logic [2:0]  pix_color,
   output logic        frame_start,
   output logic        locked,
   output logic [10:0] line_len,
   output logic [10:0] frame_lines,
   output logic        lock_err
);
   typedef enum logic [1:0] {SEARCH = 2'd0, CHECK = 2'd1, LOCKED = 2'd2} state_t;

   localparam logic        HP       = (HPOL != 0);
   localparam logic        VP       = (VPOL != 0);
   localparam logic [10:0] CNT_MAX  = 11'h7FF;
   localparam logic [10:0] H_OFS    = 11'(H_START);
   localparam logic [10:0] V_OFS    = 11'(V_START);
   localparam logic [11:0] H_LO     = 12'(H_START);
   localparam logic [11:0] H_HI     = 12'(H_START + HRES);
   localparam logic [11:0] V_LO     = 12'(V_START);
   localparam logic [11:0] V_HI     = 12'(V_START + VRES);
   localparam logic [10:0] MIN_L    = 11'(MIN_LINE);
   localparam logic [10:0] MIN_F    = 11'(MIN_FRAME);

   function automatic logic [10:0] sat_inc(input logic [10:0] v);
      sat_inc = (v == CNT_MAX) ? v : v + 11'd1;
   endfunction

   logic [4:0]  sync1_q, sync2_q;
   logic        hs_prev_q, vs_prev_q;
   logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
   logic [10:0] line_len_q, line_len_d, frame_lines_q, frame_lines_d;
   logic [10:0] first_len_q, first_len_d, ref_len_q, ref_len_d, ref_lines_q, ref_lines_d;
   logic        first_seen_q, first_seen_d, line_bad_q, line_bad_d;
   state_t      state_q, state_d;
   logic        pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
   logic [10:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
   logic [2:0]  pix_color_q, pix_color_d;
   logic        locked_q, lock_err_q;
   logic        hs_n_s, vs_n_s, hs_edge_s, vs_edge_s, len_diff_s, bad_now_s;
   logic        ref_ok_s, mismatch_s, lock_ok_s;
   logic [10:0] meas_len_s, meas_lines_s;

   // Edge detection, counters and per-frame line-length consistency tracking.
   always_comb begin
      hs_n_s       = sync2_q[1] ~^ HP;
      vs_n_s       = sync2_q[0] ~^ VP;
      hs_edge_s    = hs_n_s & ~hs_prev_q;
      vs_edge_s    = vs_n_s & ~vs_prev_q;
      meas_len_s   = sat_inc(hcnt_q);
      meas_lines_s = sat_inc(vcnt_q);
      hcnt_d       = hs_edge_s ? 11'd0 : meas_len_s;
      if (vs_edge_s) begin
         vcnt_d = 11'd0;
      end else if (hs_edge_s) begin
         vcnt_d = meas_lines_s;
      end else begin
         vcnt_d = vcnt_q;
      end
      line_len_d    = hs_edge_s ? meas_len_s : line_len_q;
      frame_lines_d = vs_edge_s ? meas_lines_s : frame_lines_q;
      len_diff_s    = hs_edge_s & first_seen_q & (meas_len_s != first_len_q);
      bad_now_s     = line_bad_q | len_diff_s;
      first_len_d   = first_len_q;
      first_seen_d  = first_seen_q;
      line_bad_d    = bad_now_s;
      // The line closed by a vsync edge belongs to the frame that just ended.
      if (vs_edge_s) begin
         first_seen_d = 1'b0;
         line_bad_d   = 1'b0;
      end else if (hs_edge_s && !first_seen_q) begin
         first_seen_d = 1'b1;
         first_len_d  = meas_len_s;
      end else begin
         first_seen_d = first_seen_q;
      end
   end

   // Lock state machine and next pixel-output values.
   always_comb begin
      state_d     = state_q;
      ref_len_d   = ref_len_q;
      ref_lines_d = ref_lines_q;
      ref_ok_s    = !bad_now_s && (line_len_d == ref_len_q) && (frame_lines_d == ref_lines_q) &&
                    (line_len_d >= MIN_L) && (frame_lines_d >= MIN_F);
      mismatch_s  = (hs_edge_s && (meas_len_s != ref_len_q)) ||
                    (vs_edge_s && (meas_lines_s != ref_lines_q)) ||
                    (hcnt_q == CNT_MAX) || (vcnt_q == CNT_MAX);
      case (state_q)
         SEARCH: begin
            if (vs_edge_s) begin
               state_d     = CHECK;
               ref_len_d   = line_len_d;
               ref_lines_d = frame_lines_d;
            end else begin
               state_d = SEARCH;
            end
         end
         CHECK: begin
            if (vs_edge_s && ref_ok_s) begin
               state_d = LOCKED;
            end else if (vs_edge_s) begin
               ref_len_d   = line_len_d;
               ref_lines_d = frame_lines_d;
            end else begin
               state_d = CHECK;
            end
         end
         LOCKED: begin
            if (mismatch_s) begin
               state_d = SEARCH;
            end else begin
               state_d = LOCKED;
            end
         end
         default: state_d = SEARCH;
      endcase
      lock_ok_s   = (state_d == LOCKED);
      pix_valid_d = lock_ok_s && ({1'b0, hcnt_d} >= H_LO) && ({1'b0, hcnt_d} < H_HI) &&
                    ({1'b0, vcnt_d} >= V_LO) && ({1'b0, vcnt_d} < V_HI);
      if (pix_valid_d) begin
         pix_x_d     = hcnt_d - H_OFS;
         pix_y_d     = vcnt_d - V_OFS;
         pix_color_d = sync2_q[4:2];
      end else begin
         pix_x_d     = pix_x_q;
         pix_y_d     = pix_y_q;
         pix_color_d = pix_color_q;
      end
      frame_start_d = pix_valid_d && (hcnt_d == H_OFS) && (vcnt_d == V_OFS);
   end

   // State registers; a sync already active at reset is not treated as a leading edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 5'd0;            sync2_q <= 5'd0;
         hs_prev_q <= 1'b1;          vs_prev_q <= 1'b1;
         hcnt_q <= 11'd0;            vcnt_q <= 11'd0;
         line_len_q <= 11'd0;        frame_lines_q <= 11'd0;
         first_len_q <= 11'd0;       first_seen_q <= 1'b0;
         line_bad_q <= 1'b0;         state_q <= SEARCH;
         ref_len_q <= 11'd0;         ref_lines_q <= 11'd0;
         pix_valid_q <= 1'b0;        frame_start_q <= 1'b0;
         pix_x_q <= 11'd0;           pix_y_q <= 11'd0;
         pix_color_q <= 3'd0;        locked_q <= 1'b0;
         lock_err_q <= 1'b0;
      end else begin
         sync1_q <= {red, green, blue, hsync, vsync};
         sync2_q <= sync1_q;
         hs_prev_q <= hs_n_s;        vs_prev_q <= vs_n_s;
         hcnt_q <= hcnt_d;           vcnt_q <= vcnt_d;
         line_len_q <= line_len_d;   frame_lines_q <= frame_lines_d;
         first_len_q <= first_len_d; first_seen_q <= first_seen_d;
         line_bad_q <= line_bad_d;   state_q <= state_d;
         ref_len_q <= ref_len_d;     ref_lines_q <= ref_lines_d;
         pix_valid_q <= pix_valid_d; frame_start_q <= frame_start_d;
         pix_x_q <= pix_x_d;         pix_y_q <= pix_y_d;
         pix_color_q <= pix_color_d; locked_q <= lock_ok_s;
         lock_err_q <= (state_q == LOCKED) && !lock_ok_s;
      end
   end

   assign pix_valid   = pix_valid_q;
   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign pix_color   = pix_color_q;
   assign frame_start = frame_start_q;
   assign locked      = locked_q;
   assign line_len    = line_len_q;
   assign frame_lines = frame_lines_q;
   assign lock_err    = lock_err_q;
endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture on a reduced 8x4 raster (20 clocks x 10 lines); one instance
// sees active-high syncs, the other the inverted syncs with HPOL=VPOL=0.
module tb_vga_capture;
   logic clk = 1'b0;
   logic rst = 1'b0;
   logic hs_pin = 1'b0, vs_pin = 1'b0;
   logic [2:0] rgb_pin = 3'd0;
   logic hs_inv, vs_inv;
   logic [1:0] pv, fs, lk, le;
   logic [1:0][10:0] px, py, ll, fl;
   logic [1:0][2:0] pc;

   int n_cmp = 0, n_mis = 0;
   int pcnt[2], fcnt[2], lecnt[2], pb[2], fb[2];
   logic [25:0] h1 = 26'd0, h2 = 26'd0, h3 = 26'd0;
   logic rst_pend = 1'b0;

   assign hs_inv = ~hs_pin;
   assign vs_inv = ~vs_pin;

   always #5 clk = ~clk;

   vga_capture #(.HRES(8), .VRES(4), .H_START(6), .V_START(3), .HPOL(1), .VPOL(1),
                 .MIN_LINE(16), .MIN_FRAME(8)) u_dut_pos (
      .clk(clk), .rst(rst), .red(rgb_pin[2]), .green(rgb_pin[1]), .blue(rgb_pin[0]),
      .hsync(hs_pin), .vsync(vs_pin), .pix_valid(pv[0]), .pix_x(px[0]), .pix_y(py[0]),
      .pix_color(pc[0]), .frame_start(fs[0]), .locked(lk[0]), .line_len(ll[0]),
      .frame_lines(fl[0]), .lock_err(le[0]));

   vga_capture #(.HRES(8), .VRES(4), .H_START(6), .V_START(3), .HPOL(0), .VPOL(0),
                 .MIN_LINE(16), .MIN_FRAME(8)) u_dut_neg (
      .clk(clk), .rst(rst), .red(rgb_pin[2]), .green(rgb_pin[1]), .blue(rgb_pin[0]),
      .hsync(hs_inv), .vsync(vs_inv), .pix_valid(pv[1]), .pix_x(px[1]), .pix_y(py[1]),
      .pix_color(pc[1]), .frame_start(fs[1]), .locked(lk[1]), .line_len(ll[1]),
      .frame_lines(fl[1]), .lock_err(le[1]));

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0d, wanted %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] pat(input int x, input int y);
      return 3'((x * 3 + y) % 8);
   endfunction

   task automatic check_zero();
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("dut%0d.rst_pix_valid", i), 32'(pv[i]), 32'd0);
         check_eq($sformatf("dut%0d.rst_pix_x", i), 32'(px[i]), 32'd0);
         check_eq($sformatf("dut%0d.rst_pix_y", i), 32'(py[i]), 32'd0);
         check_eq($sformatf("dut%0d.rst_pix_color", i), 32'(pc[i]), 32'd0);
         check_eq($sformatf("dut%0d.rst_frame_start", i), 32'(fs[i]), 32'd0);
         check_eq($sformatf("dut%0d.rst_locked", i), 32'(lk[i]), 32'd0);
         check_eq($sformatf("dut%0d.rst_line_len", i), 32'(ll[i]), 32'd0);
         check_eq($sformatf("dut%0d.rst_frame_lines", i), 32'(fl[i]), 32'd0);
         check_eq($sformatf("dut%0d.rst_lock_err", i), 32'(le[i]), 32'd0);
      end
   endtask

   // One clock: inspect outputs (3 ticks behind the pins), then drive the next pin sample.
   task automatic tick(input logic r, input logic hs, input logic vs, input logic act,
                       input logic [10:0] x, input logic [10:0] y, input logic [2:0] c);
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
         if (pv[i] === 1'b1) begin
            pcnt[i]++;
            check_eq($sformatf("dut%0d.pix_in_window", i), 32'(pv[i]), 32'(h3[25]));
            check_eq($sformatf("dut%0d.pix_x", i), 32'(px[i]), 32'(h3[24:14]));
            check_eq($sformatf("dut%0d.pix_y", i), 32'(py[i]), 32'(h3[13:3]));
            check_eq($sformatf("dut%0d.pix_color", i), 32'(pc[i]), 32'(h3[2:0]));
            check_eq($sformatf("dut%0d.frame_start", i), 32'(fs[i]),
                     32'((h3[24:14] == 11'd0) && (h3[13:3] == 11'd0)));
         end
         if (fs[i] === 1'b1) fcnt[i]++;
         if (le[i] === 1'b1) lecnt[i]++;
      end
      if (rst_pend) check_zero();
      rst_pend = r;
      h3 = h2;
      h2 = h1;
      h1 = {act, x, y, c};
      rst = r;
      hs_pin = hs;
      vs_pin = vs;
      rgb_pin = c;
   endtask

   task automatic idle(input int n, input logic r);
      for (int k = 0; k < n; k++) tick(r, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 3'd0);
   endtask

   // Ten-line frame: 2-clock hsync, 1-line vsync, active h 6..13 / v 3..6.
   task automatic run_frame(input int llen, input int short_line, input int rst_line,
                            input int rst_h);
      int len;
      logic act;
      for (int i = 0; i < 2; i++) begin
         pb[i] = pcnt[i];
         fb[i] = fcnt[i];
      end
      for (int v = 0; v < 10; v++) begin
         len = (v == short_line) ? llen - 1 : llen;
         for (int h = 0; h < len; h++) begin
            act = (h >= 6) && (h < 14) && (v >= 3) && (v < 7);
            tick((v == rst_line) && (h == rst_h), h < 2, v < 1, act,
                 act ? 11'(h - 6) : 11'd0, act ? 11'(v - 3) : 11'd0,
                 act ? pat(h - 6, v - 3) : 3'b101);
         end
      end
   endtask

   task automatic check_frame(input string tag, input int e_pix, input int e_fs,
                              input logic e_lk, input int e_ll, input int e_fl);
      for (int i = 0; i < 2; i++) begin
         check_eq($sformatf("dut%0d.%s.pixels", i, tag), 32'(pcnt[i] - pb[i]), 32'(e_pix));
         check_eq($sformatf("dut%0d.%s.frame_starts", i, tag), 32'(fcnt[i] - fb[i]), 32'(e_fs));
         check_eq($sformatf("dut%0d.%s.locked", i, tag), 32'(lk[i]), 32'(e_lk));
         check_eq($sformatf("dut%0d.%s.line_len", i, tag), 32'(ll[i]), 32'(e_ll));
         check_eq($sformatf("dut%0d.%s.frame_lines", i, tag), 32'(fl[i]), 32'(e_fl));
      end
   endtask

   task automatic check_errs(input string tag, input int e_cnt);
      for (int i = 0; i < 2; i++)
         check_eq($sformatf("dut%0d.%s.lock_err_pulses", i, tag), 32'(lecnt[i]), 32'(e_cnt));
   endtask

   initial begin
      for (int i = 0; i < 2; i++) begin
         pcnt[i] = 0; fcnt[i] = 0; lecnt[i] = 0; pb[i] = 0; fb[i] = 0;
      end
      idle(3, 1'b1);
      idle(7, 1'b0);
      run_frame(20, -1, -1, -1);  check_frame("f1", 0, 0, 1'b0, 20, 1);
      run_frame(20, -1, -1, -1);  check_frame("f2", 0, 0, 1'b0, 20, 10);
      run_frame(20, -1, -1, -1);  check_frame("f3", 32, 1, 1'b1, 20, 10);
      run_frame(20, -1, -1, -1);  check_frame("f4", 32, 1, 1'b1, 20, 10);
      check_errs("f4", 0);
      // Line 5 one clock short while locked.
      run_frame(20, 5, -1, -1);   check_frame("f5_short", 24, 1, 1'b0, 20, 10);
      check_errs("f5_short", 1);
      run_frame(20, -1, -1, -1);  check_frame("f6", 0, 0, 1'b0, 20, 10);
      run_frame(20, -1, -1, -1);
      run_frame(20, -1, -1, -1);  check_frame("f8", 32, 1, 1'b1, 20, 10);
      // Reset pulse mid-active line 4 while locked.
      run_frame(20, -1, 4, 8);    check_frame("f9_rst", 8, 1, 1'b0, 20, 0);
      run_frame(20, -1, -1, -1);  check_frame("f10", 0, 0, 1'b0, 20, 6);
      run_frame(20, -1, -1, -1);  check_frame("f11", 0, 0, 1'b0, 20, 10);
      run_frame(20, -1, -1, -1);  check_frame("f12", 32, 1, 1'b1, 20, 10);
      check_errs("f12", 1);
      // Lines shorter than MIN_LINE never lock.
      idle(2, 1'b1);
      idle(5, 1'b0);
      run_frame(12, -1, -1, -1);  check_frame("f13_short_line", 0, 0, 1'b0, 12, 1);
      run_frame(12, -1, -1, -1);  check_frame("f14_short_line", 0, 0, 1'b0, 12, 10);
      run_frame(12, -1, -1, -1);  check_frame("f15_short_line", 0, 0, 1'b0, 12, 10);
      run_frame(12, -1, -1, -1);  check_frame("f16_short_line", 0, 0, 1'b0, 12, 10);
      check_errs("f16", 1);
      idle(4, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

// File: doc/vga_capture.md
Name: vga_capture

Overview:
- Receive-side counterpart of the VGA driver: samples a 3-bit RGB + hsync/vsync stream on the pixel clock.
- Recovers line/frame timing, measures line length and lines per frame, and declares lock after two consistent frames.
- While locked, emits an (x, y, color) pixel-write stream for the active window, suitable for filling a frame buffer or checking the driver in loopback.
- Sits between the board VGA input pins (or the driver outputs in loopback) and the frame/colour memory.

Parameters:
- HRES, 800, active pixels per line
- VRES, 600, active lines per frame
- H_START, 216, pixel clocks from hsync leading edge to first active pixel (sync 128 + back porch 88)
- V_START, 27, lines from vsync leading edge to first active line (sync 4 + back porch 23)
- HPOL, 1, hsync active level (1 = active high)
- VPOL, 1, vsync active level
- MIN_LINE, 64, minimum valid line length in clocks
- MIN_FRAME, 16, minimum valid lines per frame

Ports:
- clk  in  1  pixel clock (40 MHz for 800x600)
- rst  in  1  synchronous reset, active-high
- red, green, blue  in  1 each  colour inputs, asynchronous to clk
- hsync, vsync  in  1 each  sync inputs, asynchronous to clk
- pix_valid  out  1  pixel strobe, one per active pixel
- pix_x  out  11  active column, 0..HRES-1
- pix_y  out  11  active row, 0..VRES-1
- pix_color  out  3  {red, green, blue}
- frame_start  out  1  one-cycle pulse coincident with the pixel at x=0, y=0
- locked  out  1  timing lock status
- line_len  out  11  last measured clocks per line
- frame_lines  out  11  last measured lines per frame
- lock_err  out  1  one-cycle pulse when lock is lost

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All outputs 0.
  - FSM returns to SEARCH; synchronizers and counters clear.
  - Reset mid-frame drops lock immediately; pix_valid goes low on the following cycle.
- Input path:
  - All five inputs pass through a 2-FF synchronizer.
  - Syncs are polarity-normalised with HPOL/VPOL.
  - Leading edge = normalised sync goes 0 then 1 across consecutive synchronized samples.
- Horizontal counter hcnt (11 bit):
  - Set to 0 for the sample carrying the hsync leading edge; otherwise increments.
  - Saturates at 2047 (no wrap).
- Vertical counter vcnt (11 bit):
  - On a vsync leading edge: vcnt <= 0. This has priority over a simultaneous hsync edge; that line is line 0.
  - On an hsync leading edge without a vsync edge: vcnt <= vcnt + 1, saturating at 2047.
- Measurement:
  - At each hsync edge: line_len <= hcnt + 1, saturated to 2047.
  - At each vsync edge: frame_lines <= vcnt + 1.
  - A per-frame sticky flag line_bad sets if any hsync-edge measurement differs from the first line_len of that frame. It clears at the vsync edge.
- Lock FSM (all transitions evaluated at vsync leading edges only):
  - SEARCH: first vsync edge -> CHECK; store ref_len and ref_lines.
  - CHECK: if line_bad = 0, measured length equals ref_len, lines equal ref_lines, line_len >= MIN_LINE and frame_lines >= MIN_FRAME -> LOCKED. Otherwise stay in CHECK and reload the references.
  - LOCKED: locked = 1.
    - A line-length mismatch at any hsync edge, or a frame_lines mismatch at a vsync edge, -> SEARCH.
    - On that transition, locked = 0 and lock_err pulses 1 cycle.
    - hcnt/vcnt saturation while LOCKED is also a mismatch.
- Pixel output:
  - pix_valid = locked && (H_START <= hcnt < H_START + HRES) && (V_START <= vcnt < V_START + VRES).
  - pix_x = hcnt - H_START; pix_y = vcnt - V_START; pix_color is the synchronized RGB of the same sample.
  - All pixel outputs are registered.
  - Pin-to-output latency is exactly 3 clk cycles (2 synchronizer + 1 output register). pix_x=0 is the pixel on the pins H_START clocks after the first asserted hsync sample.
  - When pix_valid = 0, pix_x/pix_y/pix_color hold their last values.
  - frame_start = pix_valid && pix_x==0 && pix_y==0.
- Lines longer than H_START+HRES and frames taller than V_START+VRES are accepted; excess area is blanking.

Test Plan:
- Loopback from vga_driver at 800x600 defaults, 3 frames -> line_len=1056, frame_lines=628. locked rises at the 3rd vsync edge. Frame 4 gives exactly 480000 pix_valid pulses, one frame_start, and pix_x/pix_y/pix_color matching the driver's colour pattern with 3-cycle latency.
- Simultaneous hsync and vsync leading edges on one sample -> vcnt=0 for that line; frame_lines unchanged at 628; no lock_err.
- Once locked, shorten one line to 1055 clocks -> lock_err pulses once and locked=0 on the next cycle. pix_valid stays 0 until two further clean frames, then relock.
- HPOL=0, VPOL=0 with inverted sync stimulus -> identical results to the first scenario.
- Assert rst for 1 cycle mid-active-line while locked -> the next cycle has all outputs 0 and locked=0; relock takes 2 full frames after the next vsync edge.
- Drive hsync every 32 clocks (below MIN_LINE=64) -> locked never asserts; pix_valid stays 0; line_len=32.
